// File: rtl/lms_weight_seq.sv
// LMS weight RAM sequencer: CLEAR, FILTER and UPDATE sweeps over the taps.
// It is the only master of both ports of the weight RAM; the RAM read latency is 1 cycle.
module lms_weight_seq #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 59,
    parameter int TAPS       = 512,
    parameter int X_WIDTH    = 16,
    parameter int ERR_WIDTH  = 24,
    parameter int MU_SHIFT   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_clr,
    input  logic                  start_filt,
    input  logic                  start_upd,
    input  logic [ERR_WIDTH-1:0]  err,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  ram_rst,
    output logic [ADDR_WIDTH-1:0] x_rd_addr,
    input  logic [X_WIDTH-1:0]    x_rd_data,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  w_out_valid,
    output logic [ADDR_WIDTH-1:0] w_out_idx
);

    localparam int PW = X_WIDTH + ERR_WIDTH;
    localparam int SW = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(TAPS - 1);
    localparam logic [DATA_WIDTH-1:0] W_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] W_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FILT,
        S_UPD,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  k_q, k_d;
    logic                   done_q, done_d;
    logic [ERR_WIDTH-1:0]   err_q, err_d;

    logic                   filt_v_q;
    logic [ADDR_WIDTH-1:0]  filt_idx_q;
    logic                   upd_v1_q, upd_v2_q;
    logic [ADDR_WIDTH-1:0]  upd_a1_q, upd_a2_q;
    logic signed [PW-1:0]   prod_q;
    logic signed [DATA_WIDTH-1:0] w1_q;

    logic signed [PW-1:0]   prod_d;
    logic signed [PW-1:0]   step;
    logic signed [SW-1:0]   sum;
    logic [DATA_WIDTH-1:0]  sat;

    // Sweep control. The counter returns to 0 at the last tap so IDLE always sees k=0.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (start_clr) begin
                    state_d = S_CLR;
                end else if (start_filt) begin
                    state_d = S_FILT;
                end else if (start_upd) begin
                    state_d = S_UPD;
                    err_d   = err;
                end
            end
            S_CLR, S_FILT, S_UPD: begin
                if (k_q == LAST_K) begin
                    k_d = '0;
                    if (state_q == S_CLR) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    k_d = k_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // Once stage 1 is empty, the final write or stream word is in flight this cycle.
                if (!upd_v1_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign prod_d = PW'($signed(err_q)) * PW'($signed(x_rd_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_v_q   <= 1'b0;
            filt_idx_q <= '0;
            upd_v1_q   <= 1'b0;
            upd_v2_q   <= 1'b0;
            upd_a1_q   <= '0;
            upd_a2_q   <= '0;
            prod_q     <= '0;
            w1_q       <= '0;
        end else begin
            filt_v_q   <= (state_q == S_FILT);
            filt_idx_q <= k_q;
            upd_v1_q   <= (state_q == S_UPD);
            upd_a1_q   <= k_q;
            upd_v2_q   <= upd_v1_q;
            upd_a2_q   <= upd_a1_q;
            if (upd_v1_q) begin
                prod_q <= prod_d;
                w1_q   <= $signed(ram_rd_data);
            end
        end
    end

    // One guard bit catches overflow; saturate toward the sign of the true sum.
    always_comb begin
        step = prod_q >>> MU_SHIFT;
        sum  = SW'(w1_q) + SW'(step);
        sat  = sum[DATA_WIDTH-1:0];
        if (sum[SW-1] != sum[SW-2]) begin
            sat = sum[SW-1] ? W_MIN : W_MAX;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign ram_rst     = ~rst_n;
    assign ram_wr_en   = (state_q == S_CLR) | upd_v2_q;
    assign ram_wr_addr = upd_v2_q ? upd_a2_q : ((state_q == S_CLR) ? k_q : '0);
    assign ram_wr_data = upd_v2_q ? sat : '0;
    assign ram_rd_addr = ((state_q == S_FILT) || (state_q == S_UPD)) ? k_q : '0;
    assign x_rd_addr   = (state_q == S_UPD) ? k_q : '0;
    assign w_out_valid = filt_v_q;
    assign w_out       = filt_v_q ? ram_rd_data : '0;
    assign w_out_idx   = filt_v_q ? filt_idx_q : '0;

endmodule

// File: tb/tb_lms_weight_seq.sv
// Directed bench for lms_weight_seq with a behavioural weight RAM and delay line.
module tb_lms_weight_seq;

    localparam int AW = 9, DW = 59, TAPS = 512, XW = 16, EW = 24, MU = 12;
    localparam logic [DW-1:0] WMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] WMIN = {1'b1, {(DW-1){1'b0}}};

    logic          clk, rst_n;
    logic          start_clr, start_filt, start_upd;
    logic [EW-1:0] err;
    logic          busy, done;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr, x_rd_addr, w_out_idx;
    logic [DW-1:0] ram_wr_data, ram_rd_data, w_out;
    logic          ram_wr_en, ram_rst, w_out_valid;
    logic [XW-1:0] x_rd_data;

    logic [DW-1:0] w_mem [TAPS];
    logic [DW-1:0] ld_w  [TAPS];
    logic [DW-1:0] ref_w [TAPS];
    logic [XW-1:0] x_mem [TAPS];
    logic          load_req;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DW-1:0] w;
        logic [XW-1:0] x;
        logic [EW-1:0] e;
        logic [DW-1:0] exp_w;
    } vec_t;
    vec_t vt [9];

    lms_weight_seq #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAPS(TAPS),
        .X_WIDTH(XW), .ERR_WIDTH(EW), .MU_SHIFT(MU)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_clr(start_clr), .start_filt(start_filt), .start_upd(start_upd),
        .err(err), .busy(busy), .done(done),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .ram_rst(ram_rst),
        .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .w_out(w_out), .w_out_valid(w_out_valid), .w_out_idx(w_out_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < TAPS; i++) w_mem[i] <= ld_w[i];
        end else if (ram_wr_en) begin
            w_mem[ram_wr_addr] <= ram_wr_data;
        end
        ram_rd_data <= w_mem[ram_rd_addr];
        x_rd_data   <= x_mem[x_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic load_w();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // kind: 0 CLR, 1 FILT, 2 UPD. Start sits in cycle 0; cycle c is sampled c negedges later.
    task automatic sweep(input int kind, input logic [EW-1:0] e, input bit collide, input int poke,
                         output int done_cyc, output int ndone, output int bad);
        int   last;
        logic exp_wr, exp_v;
        last     = (kind == 0) ? TAPS : (kind == 1) ? TAPS + 1 : TAPS + 2;
        done_cyc = -1;
        ndone    = 0;
        bad      = 0;
        @(negedge clk);
        err        = e;
        start_clr  = (kind == 0);
        start_filt = (kind == 1);
        start_upd  = (kind == 2) || collide;
        for (int c = 1; c <= TAPS + 10; c++) begin
            @(negedge clk);
            start_clr  = 1'b0;
            start_upd  = 1'b0;
            start_filt = (c == poke);
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy !== (c <= last)) bad++;
            exp_wr = (kind == 0) ? (c <= TAPS) : (kind == 2) ? (c >= 3 && c <= TAPS + 2) : 1'b0;
            exp_v  = (kind == 1) && (c >= 2) && (c <= TAPS + 1);
            if (ram_wr_en !== exp_wr) bad++;
            else if (exp_wr) begin
                if (kind == 0 && (ram_wr_addr !== AW'(c - 1) || ram_wr_data !== '0)) bad++;
                if (kind == 2 && ram_wr_addr !== AW'(c - 3)) bad++;
            end
            if (w_out_valid !== exp_v) bad++;
            else if (exp_v && (w_out_idx !== AW'(c - 2) || w_out !== ref_w[c - 2])) bad++;
        end
        start_filt = 1'b0;
    endtask

    initial begin
        int dc, nd, bd, cnt;
        rst_n = 1'b0; start_clr = 1'b0; start_filt = 1'b0; start_upd = 1'b0;
        err = '0; load_req = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            x_mem[i] = '0; ld_w[i] = '0; ref_w[i] = '0;
        end
        vt[0] = '{59'd1000, 16'd5, 24'd4096, 59'd1005};
        vt[1] = '{59'd1000, -16'sd3, 24'd4096, 59'd997};
        vt[2] = '{59'd0, 16'd1, 24'd1, 59'd0};
        vt[3] = '{59'd0, -16'sd1, 24'd1, {DW{1'b1}}};
        vt[4] = '{-59'sd50, 16'd100, -24'sd8192, -59'sd250};
        vt[5] = '{WMAX - 59'd9, 16'd32767, 24'd8388607, WMAX};
        vt[6] = '{WMIN + 59'd10, 16'd32767, -24'sd8388608, WMIN};
        vt[7] = '{WMAX, 16'd0, 24'd8388607, WMAX};
        vt[8] = '{59'd123456789, -16'sd32768, -24'sd8388608, 59'd190565653};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_wr_en", 64'(ram_wr_en), 0);
        check("rst_w_out_valid", 64'(w_out_valid), 0);
        check("rst_wr_addr", 64'(ram_wr_addr), 0);
        check("rst_rd_addr", 64'(ram_rd_addr), 0);
        check("rst_w_out", 64'(w_out), 0);
        check("rst_ram_rst", 64'(ram_rst), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("ram_rst_released", 64'(ram_rst), 0);

        // CLEAR over nonzero content, then FILTER readback of zeros
        for (int i = 0; i < TAPS; i++) ld_w[i] = DW'(i + 7);
        load_w();
        sweep(0, '0, 1'b0, 0, dc, nd, bd);
        check("clr_protocol_bad", 64'(bd), 0);
        check("clr_done_cycle", 64'(dc), TAPS + 1);
        check("clr_done_count", 64'(nd), 1);
        cnt = 0;
        for (int i = 0; i < TAPS; i++) if (w_mem[i] !== '0) cnt++;
        check("clr_nonzero_words", 64'(cnt), 0);
        for (int i = 0; i < TAPS; i++) ref_w[i] = '0;
        sweep(1, '0, 1'b0, 0, dc, nd, bd);
        check("filt_zero_bad", 64'(bd), 0);
        check("filt_zero_done_cycle", 64'(dc), TAPS + 2);

        // FILTER of w[k]=k
        for (int i = 0; i < TAPS; i++) begin
            ld_w[i] = DW'(i); ref_w[i] = DW'(i);
        end
        load_w();
        sweep(1, '0, 1'b0, 0, dc, nd, bd);
        check("filt_ramp_bad", 64'(bd), 0);
        check("filt_ramp_done_cycle", 64'(dc), TAPS + 2);
        check("filt_ramp_done_count", 64'(nd), 1);

        // UPDATE: w=1000, x=k, err=4096 -> w=1000+k
        for (int i = 0; i < TAPS; i++) begin
            ld_w[i] = DW'(1000); x_mem[i] = XW'(i);
        end
        load_w();
        sweep(2, 24'd4096, 1'b0, 0, dc, nd, bd);
        check("upd_protocol_bad", 64'(bd), 0);
        check("upd_done_cycle", 64'(dc), TAPS + 3);
        cnt = 0;
        for (int i = 0; i < TAPS; i++) if (w_mem[i] !== DW'(1000 + i)) cnt++;
        check("upd_wrong_words", 64'(cnt), 0);

        // Single-tap arithmetic and saturation vectors
        for (int i = 0; i < TAPS; i++) begin
            ld_w[i] = '0; x_mem[i] = '0;
        end
        for (int v = 0; v < 9; v++) begin
            ld_w[0]  = vt[v].w;
            x_mem[0] = vt[v].x;
            load_w();
            sweep(2, vt[v].e, 1'b0, 0, dc, nd, bd);
            check($sformatf("vec%0d_w0", v), 64'(w_mem[0]), 64'(vt[v].exp_w));
            check($sformatf("vec%0d_done_cycle", v), 64'(dc), TAPS + 3);
        end

        // start_clr + start_upd together -> CLR only; start_filt mid-sweep ignored
        for (int i = 0; i < TAPS; i++) ld_w[i] = DW'(i + 1);
        load_w();
        sweep(0, 24'd4096, 1'b1, 50, dc, nd, bd);
        check("collide_protocol_bad", 64'(bd), 0);
        check("collide_done_cycle", 64'(dc), TAPS + 1);
        check("collide_done_count", 64'(nd), 1);
        cnt = 0;
        for (int i = 0; i < TAPS; i++) if (w_mem[i] !== '0) cnt++;
        check("collide_nonzero_words", 64'(cnt), 0);

        // Reset in cycle 100 of an UPDATE: writes 0..96 committed, nothing after
        for (int i = 0; i < TAPS; i++) begin
            ld_w[i] = DW'(1000); x_mem[i] = XW'(i);
        end
        load_w();
        @(negedge clk);
        err = 24'd4096;
        start_upd = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_upd = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("abort_wr_en", 64'(ram_wr_en), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_ram_rst", 64'(ram_rst), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_w96", 64'(w_mem[96]), 1096);
        check("abort_w97", 64'(w_mem[97]), 1000);
        check("abort_w511", 64'(w_mem[511]), 1000);
        for (int i = 0; i < TAPS; i++) ref_w[i] = (i < 97) ? DW'(1000 + i) : DW'(1000);
        sweep(1, '0, 1'b0, 0, dc, nd, bd);
        check("post_reset_filt_bad", 64'(bd), 0);
        check("post_reset_filt_done_cycle", 64'(dc), TAPS + 2);
        check("post_reset_filt_done_count", 64'(nd), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
